// File: rtl/apb_master.sv
// apb_master: APB requester that runs single valid/ready commands as SETUP->ACCESS transfers
// and returns a one-cycle response pulse, with a watchdog for a stuck PREADY.
module apb_master #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PSLVERR
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic                  rvalid_q;
    logic                  err_q;
    logic                  to_q;

    assign cmd_ready   = state_q == IDLE;
    assign PADDR       = paddr_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = to_q;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            rvalid_q <= 1'b0;
            case (state_q)
                IDLE: if (cmd_valid) begin
                    paddr_q  <= cmd_addr;
                    pwdata_q <= cmd_wdata;
                    pwrite_q <= cmd_write;
                    psel_q   <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= SETUP;
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: if (PREADY || cnt_q == LIMIT) begin
                    // a PREADY arriving on the last allowed cycle still wins over the watchdog
                    rdata_q   <= (PREADY && !pwrite_q) ? PRDATA : '0;
                    err_q     <= PREADY ? PSLVERR : 1'b1;
                    to_q      <= !PREADY;
                    rvalid_q  <= 1'b1;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    state_q   <= IDLE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: randomized and directed checks of apb_master against a transaction-level
// latency/response model (TIMEOUT=4).
module tb_apb_master;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic [AW-1:0] PADDR;
    logic          PSELx;
    logic          PENABLE;
    logic          PWRITE;
    logic [DW-1:0] PWDATA;
    logic          PREADY = 1'b0;
    logic [DW-1:0] PRDATA = '0;
    logic          PSLVERR = 1'b0;

    int total = 0;
    int bad = 0;

    logic          cw[8];
    logic [AW-1:0] ca[8];
    logic [DW-1:0] cd[8];
    logic [DW-1:0] cpr[8];
    logic          cerr[8];
    int            cwait[8];

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .PCLK(clk), .PRESET(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    always #5 clk = ~clk;

    task automatic set_cmd(input int i);
        cmd_write = cw[i];
        cmd_addr  = ca[i];
        cmd_wdata = cd[i];
    endtask

    task automatic load(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int waits, input logic [DW-1:0] pr, input logic e);
        cw[i] = w; ca[i] = a; cd[i] = d; cwait[i] = waits; cpr[i] = pr; cerr[i] = e;
    endtask

    // Runs n queued commands with cmd_valid held high; the slave answers command i after
    // cwait[i] wait states, and never if cwait[i] >= TO.
    task automatic run_queue(input int n);
        int            lat;
        logic          exp_to;
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        exp_to = 1'b0; exp_err = 1'b0; exp_rd = '0;
        @(negedge clk);
        cmd_valid = 1'b1;
        set_cmd(0);
        PREADY = 1'b0;
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL ready_idle got=%b exp=1", cmd_ready);
        end
        for (int i = 0; i < n; i++) begin
            exp_to  = cwait[i] >= TO;
            lat     = exp_to ? 2 + TO : 3 + cwait[i];
            exp_err = exp_to | cerr[i];
            exp_rd  = (exp_to || cw[i]) ? '0 : cpr[i];
            @(posedge clk);
            for (int c = 1; c <= lat; c++) begin
                @(negedge clk);
                if (c == 1) begin
                    if (i < n - 1) set_cmd(i + 1);
                    else begin
                        cmd_valid = 1'b0;
                        cmd_write = 1'($urandom);
                        cmd_addr  = AW'($urandom);
                        cmd_wdata = DW'($urandom);
                    end
                end
                total++;
                if ({PSELx, PENABLE, rsp_valid, cmd_ready} !== {c < lat, c >= 2 && c < lat, c == lat, c == lat}) begin
                    bad++;
                    $display("FAIL phase cmd=%0d cyc=%0d got sel/en/rv/rdy=%b%b%b%b exp=%b%b%b%b", i, c,
                             PSELx, PENABLE, rsp_valid, cmd_ready, c < lat, c >= 2 && c < lat, c == lat, c == lat);
                end
                if (c < lat) begin
                    total++;
                    if ({PADDR, PWRITE} !== {ca[i], cw[i]} || (cw[i] && PWDATA !== cd[i])) begin
                        bad++;
                        $display("FAIL apb_fields cmd=%0d cyc=%0d got a=%h w=%b d=%h exp a=%h w=%b d=%h",
                                 i, c, PADDR, PWRITE, PWDATA, ca[i], cw[i], cd[i]);
                    end
                end else begin
                    total++;
                    if ({rsp_rdata, rsp_err, rsp_timeout} !== {exp_rd, exp_err, exp_to}) begin
                        bad++;
                        $display("FAIL response cmd=%0d got rd=%h err=%b to=%b exp rd=%h err=%b to=%b",
                                 i, rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_to);
                    end
                end
                PREADY  = c == 2 + cwait[i];
                PRDATA  = PREADY ? cpr[i] : DW'($urandom);
                PSLVERR = PREADY ? cerr[i] : 1'($urandom);
            end
        end
        @(negedge clk);
        PREADY = 1'b0;
        total++;
        if ({rsp_valid, PSELx, rsp_rdata, rsp_err, rsp_timeout} !== {1'b0, 1'b0, exp_rd, exp_err, exp_to}) begin
            bad++;
            $display("FAIL rsp_hold got rv=%b sel=%b rd=%h err=%b to=%b exp rv=0 sel=0 rd=%h err=%b to=%b",
                     rsp_valid, PSELx, rsp_rdata, rsp_err, rsp_timeout, exp_rd, exp_err, exp_to);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata, cmd_ready}
            !== {6'b0, {AW{1'b0}}, {DW{1'b0}}, {DW{1'b0}}, 1'b1}) begin
            bad++;
            $display("FAIL reset_state got sel=%b en=%b w=%b rv=%b err=%b to=%b a=%h d=%h rd=%h rdy=%b exp zeros rdy=1",
                     PSELx, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout, PADDR, PWDATA, rsp_rdata, cmd_ready);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_zero_wait();
        load(0, 1'b1, 4'h1, 8'hA5, 0, 8'h77, 1'b0);
        run_queue(1);
    endtask

    task automatic test_read_wait2();
        load(0, 1'b0, 4'h2, 8'h00, 2, 8'h3C, 1'b0);
        run_queue(1);
    endtask

    task automatic test_slverr();
        load(0, 1'b0, 4'h5, 8'h11, 0, 8'h99, 1'b1);
        run_queue(1);
    endtask

    task automatic test_timeout();
        load(0, 1'b0, 4'h7, 8'h00, 50, 8'h42, 1'b0);
        run_queue(1);
        load(0, 1'b0, 4'h8, 8'h00, TO - 1, 8'h5A, 1'b0);
        run_queue(1);
    endtask

    task automatic test_back_to_back();
        load(0, 1'b1, 4'h3, 8'h12, 0, 8'h00, 1'b0);
        load(1, 1'b0, 4'h4, 8'h34, 0, 8'hC3, 1'b0);
        load(2, 1'b1, 4'hF, 8'h56, 0, 8'h00, 1'b1);
        run_queue(3);
    endtask

    task automatic test_random();
        for (int r = 0; r < 10; r++) begin
            int n;
            n = int'($urandom_range(1, 4));
            for (int i = 0; i < n; i++)
                load(i, 1'($urandom), AW'($urandom), DW'($urandom), int'($urandom_range(0, TO + 1)),
                     DW'($urandom), 1'($urandom));
            run_queue(n);
        end
    endtask

    task automatic test_reset_mid();
        load(0, 1'b1, 4'h9, 8'hE7, 50, 8'h00, 1'b0);
        @(negedge clk);
        cmd_valid = 1'b1;
        set_cmd(0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total++;
        if (PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL mid_access got en=%b exp=1", PENABLE);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if ({PSELx, PENABLE} !== 2'b00) begin
            bad++;
            $display("FAIL async_drop got sel=%b en=%b exp 0 0", PSELx, PENABLE);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({rsp_valid, PSELx, cmd_ready} !== 3'b001) begin
                bad++;
                $display("FAIL reset_hold got rv=%b sel=%b rdy=%b exp 0 0 1", rsp_valid, PSELx, cmd_ready);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_rsp_after_reset got rv=%b exp=0", rsp_valid);
        end
        load(0, 1'b0, 4'h6, 8'h00, 1, 8'hB4, 1'b0);
        run_queue(1);
    endtask

    initial begin
        test_reset();
        test_write_zero_wait();
        test_read_wait2();
        test_slverr();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
